kf8259_ack_sequencer: RTL and testbench

KF8259_ACK_SEQUENCER -- requirements
Module: KF8259_Ack_Sequencer

---
 rtl/kf8259_ack_sequencer_if.sv | 44 ++++
 rtl/kf8259_ack_sequencer.sv | 167 ++++++++++++++++
 tb/tb_kf8259_ack_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kf8259_ack_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : kf8259_ack_sequencer_if
// Purpose  : Bundles the INTA handshake, request/in-service inputs and the
//            acknowledge outputs of the KF8259 acknowledge sequencer.
// Ports    : none (signal bundle only)
//            master - the surrounding controller / bus side
//            slave  - the acknowledge sequencer itself
// Revision : 1.0 - initial release
// ============================================================================
interface kf8259_ack_sequencer_if;
    logic       interrupt_acknowledge_n;
    logic [7:0] interrupt_request_register;
    logic [7:0] highest_level_in_service;
    logic [2:0] priority_rotate;
    logic       auto_eoi_config;
    logic [4:0] interrupt_vector_address;
    logic       interrupt_to_cpu;
    logic       latch_in_service;
    logic [7:0] interrupt;
    logic [7:0] clear_interrupt_request;
    logic [7:0] end_of_interrupt;
    logic [7:0] data_bus_out;
    logic       out_data_enable;

    modport master (
        output interrupt_acknowledge_n, interrupt_request_register,
               highest_level_in_service, priority_rotate, auto_eoi_config,
               interrupt_vector_address,
        input  interrupt_to_cpu, latch_in_service, interrupt,
               clear_interrupt_request, end_of_interrupt, data_bus_out,
               out_data_enable
    );

    modport slave (
        input  interrupt_acknowledge_n, interrupt_request_register,
               highest_level_in_service, priority_rotate, auto_eoi_config,
               interrupt_vector_address,
        output interrupt_to_cpu, latch_in_service, interrupt,
               clear_interrupt_request, end_of_interrupt, data_bus_out,
               out_data_enable
    );
endinterface
`default_nettype wire

// File: rtl/kf8259_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : kf8259_ack_sequencer
// Purpose  : 8259-style interrupt acknowledge sequencer (8086 mode). Resolves
//            rotating priority, raises INT, runs the two-pulse INTA sequence,
//            loads the in-service stage, returns the vector byte and issues
//            automatic EOI.
// Ports    : clock - single clock, registers update on its falling edge
//            reset - asynchronous, active-high
//            bus   - kf8259_ack_sequencer_if.slave (INTA#, IRR, ISR, rotate,
//                    AEOI, vector in; INT, latch/clear/EOI one-hots, data out)
// Revision : 1.0 - initial release
// ============================================================================
module kf8259_ack_sequencer (
    input  wire logic             clock,
    input  wire logic             reset,
    kf8259_ack_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } state_t;

    // Level reported for an acknowledge that found no request.
    localparam logic [2:0] c_SPURIOUS_LEVEL = 3'd7;

    state_t     state_q, state_d;
    logic       inta_q, inta_d;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;
    logic       int_q, int_d;
    logic       lis_q, lis_d;
    logic [7:0] intr_q, intr_d;
    logic [7:0] clr_q, clr_d;
    logic [7:0] eoi_q, eoi_d;

    logic [2:0] w_base;
    logic [7:0] w_rank_req;
    logic [7:0] w_rank_isr;
    logic       w_cand_valid;
    logic [2:0] w_cand_rank;
    logic [2:0] w_cand_level;
    logic       w_inta_fall;
    logic       w_inta_rise;

    // Rank 0 (highest priority) is the IR just above the rotate point.
    assign w_base = bus.priority_rotate + 3'd1;

    // Re-index requests and in-service bits by priority rank so the search
    // below is a plain lowest-index-first scan.
    always_comb begin
        w_rank_req = '0;
        w_rank_isr = '0;
        for (int i = 0; i < 8; i++) begin
            w_rank_req[i] = bus.interrupt_request_register[w_base + 3'(i)];
            w_rank_isr[i] = bus.highest_level_in_service[w_base + 3'(i)];
        end
    end

    // An in-service bit at or above a request's rank blocks it, so equal
    // priority never produces a candidate.
    always_comb begin
        logic stop;
        stop         = 1'b0;
        w_cand_valid = 1'b0;
        w_cand_rank  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!stop) begin
                if (w_rank_isr[i]) begin
                    stop = 1'b1;
                end else if (w_rank_req[i]) begin
                    w_cand_valid = 1'b1;
                    w_cand_rank  = 3'(i);
                    stop         = 1'b1;
                end
            end
        end
    end

    assign w_cand_level = w_cand_rank + w_base;
    assign w_inta_fall  = inta_q & ~bus.interrupt_acknowledge_n;
    assign w_inta_rise  = ~inta_q & bus.interrupt_acknowledge_n;

    always_comb begin
        state_d    = state_q;
        inta_d     = bus.interrupt_acknowledge_n;
        level_d    = level_q;
        spurious_d = spurious_q;
        int_d      = 1'b0;
        lis_d      = 1'b0;
        intr_d     = 8'h00;
        clr_d      = 8'h00;
        eoi_d      = 8'h00;
        case (state_q)
            IDLE: begin
                if (w_inta_fall) begin
                    state_d = ACK1;
                    if (w_cand_valid) begin
                        level_d    = w_cand_level;
                        spurious_d = 1'b0;
                        lis_d      = 1'b1;
                        intr_d     = 8'd1 << w_cand_level;
                        clr_d      = 8'd1 << w_cand_level;
                    end else begin
                        level_d    = c_SPURIOUS_LEVEL;
                        spurious_d = 1'b1;
                    end
                end else begin
                    int_d = w_cand_valid;
                end
            end
            ACK1: begin
                if (w_inta_fall) begin
                    state_d = ACK2;
                end
            end
            ACK2: begin
                if (w_inta_rise) begin
                    state_d = IDLE;
                    if (bus.auto_eoi_config && !spurious_q) begin
                        eoi_d = 8'd1 << level_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            inta_q     <= 1'b1;
            level_q    <= 3'd0;
            spurious_q <= 1'b0;
            int_q      <= 1'b0;
            lis_q      <= 1'b0;
            intr_q     <= 8'h00;
            clr_q      <= 8'h00;
            eoi_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            inta_q     <= inta_d;
            level_q    <= level_d;
            spurious_q <= spurious_d;
            int_q      <= int_d;
            lis_q      <= lis_d;
            intr_q     <= intr_d;
            clr_q      <= clr_d;
            eoi_q      <= eoi_d;
        end
    end

    // Vector is driven only during the second INTA low phase; the state
    // register clears asynchronously, so reset drops the bus immediately.
    assign bus.out_data_enable         = (state_q == ACK2) && !bus.interrupt_acknowledge_n;
    assign bus.data_bus_out            = bus.out_data_enable ?
                                         {bus.interrupt_vector_address, level_q} : 8'h00;
    assign bus.interrupt_to_cpu        = int_q;
    assign bus.latch_in_service        = lis_q;
    assign bus.interrupt               = intr_q;
    assign bus.clear_interrupt_request = clr_q;
    assign bus.end_of_interrupt        = eoi_q;
endmodule
`default_nettype wire

// File: tb/tb_kf8259_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_kf8259_ack_sequencer
// Purpose  : Self-checking bench for kf8259_ack_sequencer: a fixed vector
//            table, hand-written corner sequences and a randomized run
//            against a priority-rank reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_kf8259_ack_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    kf8259_ack_sequencer_if bus();

    kf8259_ack_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ic;
        logic       lis;
        logic [7:0] intr;
        logic [7:0] clr;
        logic [7:0] eoi;
        logic [7:0] dbo;
        logic       oe;
    } exp_t;

    typedef struct {
        logic       inta;
        logic [7:0] irr;
        logic       aeoi;
        logic [4:0] vec;
        exp_t       e;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int   m_phase;
    logic m_prev;
    int   m_level;
    logic m_spur;
    exp_t m_e;

    function automatic vec_t mk(logic inta, logic [7:0] irr, logic aeoi, logic [4:0] vec,
                                logic ic, logic lis, logic [7:0] intr, logic [7:0] clr,
                                logic [7:0] eoi, logic [7:0] dbo, logic oe);
        vec_t v;
        v.inta = inta; v.irr = irr; v.aeoi = aeoi; v.vec = vec;
        v.e.ic = ic; v.e.lis = lis; v.e.intr = intr; v.e.clr = clr;
        v.e.eoi = eoi; v.e.dbo = dbo; v.e.oe = oe;
        return v;
    endfunction

    // Priority by rank: rank 0 = IR(rotate+1), rank 7 = IR(rotate).
    function automatic void pick(input logic [7:0] irr, input logic [7:0] isr,
                                 input logic [2:0] rot, output logic found, output int num);
        int r;
        int best;
        int blk;
        r = int'(rot);
        best = 8; blk = 8; num = 0;
        for (int n = 0; n < 8; n++) begin
            int rank;
            rank = (n + 7 - r) % 8;
            if (isr[n] && rank < blk) blk = rank;
            if (irr[n] && rank < best) begin best = rank; num = n; end
        end
        found = (best < blk);
        if (!found) num = 0;
    endfunction

    task automatic model_step();
        exp_t n;
        logic fall, rise, found, inta;
        int   num;
        n = '0;
        inta = bus.interrupt_acknowledge_n;
        if (reset) begin
            m_phase = 0; m_prev = 1'b1; m_level = 0; m_spur = 1'b0; m_e = '0;
            return;
        end
        fall = m_prev && !inta;
        rise = !m_prev && inta;
        pick(bus.interrupt_request_register, bus.highest_level_in_service,
             bus.priority_rotate, found, num);
        if (m_phase == 0) begin
            if (fall) begin
                m_phase = 1;
                if (found) begin
                    m_level = num; m_spur = 1'b0;
                    n.lis = 1'b1; n.intr = 8'(1 << num); n.clr = 8'(1 << num);
                end else begin
                    m_level = 7; m_spur = 1'b1;
                end
            end else begin
                n.ic = found;
            end
        end else if (m_phase == 1) begin
            if (fall) m_phase = 2;
        end else if (rise) begin
            m_phase = 0;
            if (bus.auto_eoi_config && !m_spur) n.eoi = 8'(1 << m_level);
        end
        m_prev = inta;
        n.oe  = (m_phase == 2) && !inta;
        n.dbo = n.oe ? {bus.interrupt_vector_address, 3'(m_level)} : 8'h00;
        m_e = n;
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, exp_t e);
        chk({tag, ".int"},  {7'd0, bus.interrupt_to_cpu}, {7'd0, e.ic});
        chk({tag, ".lis"},  {7'd0, bus.latch_in_service}, {7'd0, e.lis});
        chk({tag, ".intr"}, bus.interrupt,                e.intr);
        chk({tag, ".clr"},  bus.clear_interrupt_request,  e.clr);
        chk({tag, ".eoi"},  bus.end_of_interrupt,         e.eoi);
        chk({tag, ".dbo"},  bus.data_bus_out,             e.dbo);
        chk({tag, ".oe"},   {7'd0, bus.out_data_enable},  {7'd0, e.oe});
    endtask

    // Inputs change 1 time unit after the rising edge; the DUT samples on
    // the falling edge and outputs are checked at the following rising edge.
    task automatic drv(logic inta, logic [7:0] irr, logic [7:0] isr, logic [2:0] rot,
                       logic aeoi, logic [4:0] vec);
        #1;
        bus.interrupt_acknowledge_n    = inta;
        bus.interrupt_request_register = irr;
        bus.highest_level_in_service   = isr;
        bus.priority_rotate            = rot;
        bus.auto_eoi_config            = aeoi;
        bus.interrupt_vector_address   = vec;
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
    endtask

    task automatic do_reset();
        drv(1'b1, 8'h00, 8'h00, 3'd7, 1'b0, 5'h00);
        reset = 1'b1;
        step();
        step();
        #1 reset = 1'b0;
    endtask

    vec_t tbl[20];

    initial begin
        bus.interrupt_acknowledge_n    = 1'b1;
        bus.interrupt_request_register = 8'h00;
        bus.highest_level_in_service   = 8'h00;
        bus.priority_rotate            = 3'd7;
        bus.auto_eoi_config            = 1'b0;
        bus.interrupt_vector_address   = 5'h00;

        //               inta irr   aeoi vec    ic lis intr   clr    eoi    dbo    oe
        tbl[0]  = mk(1'b1, 8'h04, 1'b0, 5'h01, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[1]  = mk(1'b1, 8'h04, 1'b0, 5'h01, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[2]  = mk(1'b0, 8'h04, 1'b0, 5'h01, 0, 1, 8'h04, 8'h04, 8'h00, 8'h00, 0);
        tbl[3]  = mk(1'b0, 8'h00, 1'b0, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[4]  = mk(1'b1, 8'h00, 1'b0, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[5]  = mk(1'b0, 8'h00, 1'b0, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h0A, 1);
        tbl[6]  = mk(1'b0, 8'h00, 1'b0, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h0A, 1);
        tbl[7]  = mk(1'b1, 8'h00, 1'b0, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[8]  = mk(1'b1, 8'h00, 1'b0, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[9]  = mk(1'b1, 8'h08, 1'b1, 5'h01, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[10] = mk(1'b0, 8'h08, 1'b1, 5'h01, 0, 1, 8'h08, 8'h08, 8'h00, 8'h00, 0);
        tbl[11] = mk(1'b1, 8'h00, 1'b1, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[12] = mk(1'b0, 8'h00, 1'b1, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h0B, 1);
        tbl[13] = mk(1'b1, 8'h02, 1'b1, 5'h01, 0, 0, 8'h00, 8'h00, 8'h08, 8'h00, 0);
        tbl[14] = mk(1'b1, 8'h02, 1'b1, 5'h01, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[15] = mk(1'b0, 8'h02, 1'b1, 5'h01, 0, 1, 8'h02, 8'h02, 8'h00, 8'h00, 0);
        tbl[16] = mk(1'b1, 8'h00, 1'b1, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[17] = mk(1'b0, 8'h00, 1'b1, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h09, 1);
        tbl[18] = mk(1'b1, 8'h00, 1'b1, 5'h01, 0, 0, 8'h00, 8'h00, 8'h02, 8'h00, 0);
        tbl[19] = mk(1'b1, 8'h00, 1'b1, 5'h01, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);

        // Reset state
        drv(1'b1, 8'h04, 8'h00, 3'd7, 1'b1, 5'h1F);
        step();
        chk_all("reset", '0);
        do_reset();

        // Vector table: basic acknowledge, AEOI, re-evaluation after ACK2
        for (int i = 0; i < 20; i++) begin
            drv(tbl[i].inta, tbl[i].irr, 8'h00, 3'd7, tbl[i].aeoi, tbl[i].vec);
            step();
            chk_all($sformatf("tbl%0d", i), tbl[i].e);
        end

        // Rotate 0: IR7 outranks IR0
        do_reset();
        drv(1'b1, 8'h81, 8'h00, 3'd0, 1'b0, 5'h00); step();
        drv(1'b1, 8'h81, 8'h00, 3'd0, 1'b0, 5'h00); step();
        chk("rot0.int", {7'd0, bus.interrupt_to_cpu}, 8'h01);
        drv(1'b0, 8'h81, 8'h00, 3'd0, 1'b0, 5'h00); step();
        chk("rot0.lis", {7'd0, bus.latch_in_service}, 8'h01);
        chk("rot0.intr", bus.interrupt, 8'h80);
        chk("rot0.clr", bus.clear_interrupt_request, 8'h80);
        drv(1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 5'h00); step();
        drv(1'b0, 8'h01, 8'h00, 3'd0, 1'b0, 5'h00); step();
        chk("rot0.dbo", bus.data_bus_out, 8'h07);
        drv(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 5'h00); step();

        // In-service blocking: equal/lower blocked, higher passes
        do_reset();
        drv(1'b1, 8'h08, 8'h02, 3'd7, 1'b0, 5'h00); step();
        drv(1'b1, 8'h08, 8'h02, 3'd7, 1'b0, 5'h00); step();
        chk("isr_lo.int", {7'd0, bus.interrupt_to_cpu}, 8'h00);
        drv(1'b1, 8'h08, 8'h08, 3'd7, 1'b0, 5'h00); step();
        chk("isr_eq.int", {7'd0, bus.interrupt_to_cpu}, 8'h00);
        drv(1'b1, 8'h08, 8'h10, 3'd7, 1'b0, 5'h00); step();
        chk("isr_hi.int", {7'd0, bus.interrupt_to_cpu}, 8'h01);

        // Spurious acknowledge
        do_reset();
        drv(1'b1, 8'h01, 8'h00, 3'd7, 1'b1, 5'h1F); step();
        drv(1'b1, 8'h01, 8'h00, 3'd7, 1'b1, 5'h1F); step();
        chk("spur.int1", {7'd0, bus.interrupt_to_cpu}, 8'h01);
        drv(1'b1, 8'h00, 8'h00, 3'd7, 1'b1, 5'h1F); step();
        chk("spur.int0", {7'd0, bus.interrupt_to_cpu}, 8'h00);
        drv(1'b0, 8'h00, 8'h00, 3'd7, 1'b1, 5'h1F); step();
        chk("spur.lis", {7'd0, bus.latch_in_service}, 8'h00);
        chk("spur.clr", bus.clear_interrupt_request, 8'h00);
        drv(1'b1, 8'h00, 8'h00, 3'd7, 1'b1, 5'h1F); step();
        drv(1'b0, 8'h00, 8'h00, 3'd7, 1'b1, 5'h1F); step();
        chk("spur.dbo", bus.data_bus_out, 8'hFF);
        chk("spur.oe", {7'd0, bus.out_data_enable}, 8'h01);
        drv(1'b1, 8'h00, 8'h00, 3'd7, 1'b1, 5'h1F); step();
        chk("spur.eoi", bus.end_of_interrupt, 8'h00);

        // Reset during ACK2
        do_reset();
        drv(1'b1, 8'h04, 8'h00, 3'd7, 1'b1, 5'h01); step();
        drv(1'b0, 8'h04, 8'h00, 3'd7, 1'b1, 5'h01); step();
        drv(1'b1, 8'h00, 8'h00, 3'd7, 1'b1, 5'h01); step();
        drv(1'b0, 8'h00, 8'h00, 3'd7, 1'b1, 5'h01); step();
        chk("rst2.oe_before", {7'd0, bus.out_data_enable}, 8'h01);
        chk("rst2.dbo_before", bus.data_bus_out, 8'h0A);
        #2 reset = 1'b1;
        bus.interrupt_acknowledge_n = 1'b1;
        #1;
        chk("rst2.oe_async", {7'd0, bus.out_data_enable}, 8'h00);
        chk("rst2.dbo_async", bus.data_bus_out, 8'h00);
        step();
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 8'h00, 8'h00, 3'd7, 1'b1, 5'h01); step();
            chk($sformatf("rst2.eoi%0d", i), bus.end_of_interrupt, 8'h00);
            chk($sformatf("rst2.oe%0d", i), {7'd0, bus.out_data_enable}, 8'h00);
        end
        drv(1'b1, 8'h04, 8'h00, 3'd7, 1'b1, 5'h01); step();
        chk("rst2.idle_int", {7'd0, bus.interrupt_to_cpu}, 8'h01);

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [7:0] irr;
            logic [7:0] isr;
            logic       inta;
            irr  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            isr  = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            inta = ($urandom_range(0, 2) == 0) ? ~bus.interrupt_acknowledge_n
                                               : bus.interrupt_acknowledge_n;
            drv(inta, irr, isr, 3'($urandom), 1'($urandom), 5'($urandom));
            reset = ($urandom_range(0, 199) == 0);
            step();
            chk_all($sformatf("rnd%0d", c), m_e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
